// File: rtl/led_pulse_defs.sv
// Shared state encodings for the LED pulse stretcher.
package led_pulse_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear taking priority over enable.
module up_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed ON/OFF pulses,
// queueing events that arrive while a pulse or gap is running.
module led_pulse_stretcher
    import led_pulse_defs::*;
#(
    parameter int WIDTH      = 16,
    parameter int ON_TIME    = 10000,
    parameter int OFF_TIME   = 10000,
    parameter int PEND_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trig,
    input  logic                  clr_ovf,
    output logic                  out,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [WIDTH-1:0]      ON_LAST  = WIDTH'(ON_TIME - 1);
    localparam logic [WIDTH-1:0]      OFF_LAST = WIDTH'(OFF_TIME - 1);

    state_e                state_q, state_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    logic                  out_q, busy_q;
    logic [WIDTH-1:0]      timer;
    logic                  phase_end;
    logic                  queue;
    logic                  consume;
    logic                  timer_clr;

    // Holding the timer clear in IDLE guarantees every pulse starts at zero.
    assign timer_clr = phase_end | ~rst_n | (state_q == ST_IDLE);

    up_counter #(
        .WIDTH(WIDTH)
    ) u_timer (
        .clk  (clk),
        .clr_i(timer_clr),
        .en_i (1'b1),
        .cnt_o(timer)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q & ~clr_ovf;
        phase_end = 1'b0;
        queue     = 1'b0;
        consume   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (trig) state_d = ST_ON;
            end
            ST_ON: begin
                queue = trig;
                if (timer == ON_LAST) begin
                    state_d   = ST_GAP;
                    phase_end = 1'b1;
                end
            end
            ST_GAP: begin
                if (timer == OFF_LAST) begin
                    phase_end = 1'b1;
                    if (pend_q != '0) begin
                        state_d = ST_ON;
                        consume = 1'b1;
                        queue   = trig;
                    end else if (trig) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    queue = trig;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A consume frees a slot, so a simultaneous queue never overflows.
        if (consume && !queue) begin
            pend_d = pend_q - PEND_WIDTH'(1);
        end else if (queue && !consume) begin
            if (pend_q == PEND_MAX) ovf_d = 1'b1;
            else pend_d = pend_q + PEND_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= (state_d == ST_ON);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Scoreboard bench: a behavioural model queues expected outputs per cycle.
module tb_led_pulse_stretcher;

    localparam int W    = 16;
    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    typedef struct {
        bit out;
        bit busy;
        int pend;
        bit ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    // model state: 0 idle, 1 on, 2 gap
    int m_st = 0;
    int m_t = 0;
    int m_pend = 0;
    bit m_ovf = 0;

    int pulses = 0;
    bit out_prev = 0;

    led_pulse_stretcher #(
        .WIDTH(W), .ON_TIME(ON), .OFF_TIME(OFF), .PEND_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .clr_ovf(clr_ovf),
        .out(out), .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic enqueue_evt();
        if (m_pend == PMAX) m_ovf = 1;
        else m_pend++;
    endtask

    task automatic model(input bit t, input bit c, input bit r);
        if (!r) begin
            m_st = 0; m_t = 0; m_pend = 0; m_ovf = 0;
            return;
        end
        if (c) m_ovf = 0;
        case (m_st)
            0: if (t) begin m_st = 1; m_t = 0; end
            1: begin
                if (m_t == ON - 1) begin m_st = 2; m_t = 0; end
                else m_t++;
                if (t) enqueue_evt();
            end
            default: begin
                if (m_t != OFF - 1) begin
                    m_t++;
                    if (t) enqueue_evt();
                end else if (m_pend > 0) begin
                    m_st = 1; m_t = 0; m_pend--;
                    if (t) enqueue_evt();
                end else if (t) begin
                    m_st = 1; m_t = 0;
                end else begin
                    m_st = 0;
                end
            end
        endcase
    endtask

    task automatic step(input bit t, input bit c = 0, input bit r = 1);
        exp_t e;
        exp_t g;
        trig = t; clr_ovf = c; rst_n = r;
        model(t, c, r);
        e.out = (m_st == 1); e.busy = (m_st != 0);
        e.pend = m_pend; e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("out", int'(out), int'(g.out));
        chk("busy", int'(busy), int'(g.busy));
        chk("pending", int'(pending), g.pend);
        chk("overflow", int'(overflow), int'(g.ovf));
        if (out && !out_prev) pulses++;
        out_prev = out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    initial begin
        @(posedge clk); #1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);

        // T1 single event
        pulses = 0;
        step(1);
        chk("t1_latency", int'(out), 1);
        idle(10);
        chk("t1_pulses", pulses, 1);
        chk("t1_idle", int'(busy), 0);

        // T2 three back-to-back events
        pulses = 0;
        step(1); step(1); step(1);
        chk("t2_pend", int'(pending), 2);
        idle(24);
        chk("t2_pulses", pulses, 3);

        // T3 saturation and overflow
        pulses = 0;
        for (int i = 0; i < 5; i++) step(1);
        chk("t3_sat", int'(pending), PMAX);
        chk("t3_ovf", int'(overflow), 1);
        idle(32);
        chk("t3_pulses", pulses, 4);

        // T6 clear vs set, then clear alone
        step(0, 1);
        chk("ovf_clr0", int'(overflow), 0);
        for (int i = 0; i < 5; i++) step(1);
        step(1, 1);
        chk("t6_set_wins", int'(overflow), 1);
        step(0, 1);
        chk("t6_clr", int'(overflow), 0);
        idle(32);

        // T4 trig on last gap cycle
        pulses = 0;
        step(1);
        idle(6);
        step(1);
        chk("t4_b2b_out", int'(out), 1);
        chk("t4_b2b_pend", int'(pending), 0);
        idle(10);
        chk("t4_pulses", pulses, 2);

        // T5 reset mid-operation
        pulses = 0;
        step(1); step(1); step(1);
        step(0, 0, 0);
        chk("t5_out", int'(out), 0);
        chk("t5_pend", int'(pending), 0);
        idle(16);
        chk("t5_pulses", pulses, 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 99) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
